// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: data-memory handshake FSM, load-use interlock,
// branch flush and saturating stall counter.
module pipe_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_regdst,
    input  logic             ex_branch_taken,
    input  logic             mem_MemRead,
    input  logic             mem_MemWrite,
    input  logic             dmem_ack,
    output logic [4:0]       stall,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             wb_bubble,
    output logic             dmem_req,
    output logic             dmem_err,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} state_t;

    state_t          state;
    logic [WC_W-1:0] wait_cnt;
    logic            mem_acc;
    logic            mem_stall;
    logic            load_use;

    assign mem_acc   = mem_MemRead | mem_MemWrite;
    assign mem_stall = ((state == IDLE) && mem_acc) || (state == WAIT) || (state == ERR);
    assign load_use  = ex_MemRead && (ex_regdst != 5'd0) &&
                       ((ex_regdst == id_rs) || (ex_regdst == id_rt));

    // Priority: memory stall, then branch flush, then load-use interlock.
    always_comb begin
        stall       = 5'b00000;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        wb_bubble   = 1'b0;
        if (rst) begin
            if (mem_stall) begin
                stall     = 5'b01111;
                wb_bubble = 1'b1;
            end else if (ex_branch_taken) begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (load_use) begin
                stall       = 5'b00011;
                flush_id_ex = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            dmem_req <= 1'b0;
            dmem_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (mem_acc) begin
                    state    <= WAIT;
                    wait_cnt <= '0;
                    dmem_req <= 1'b1;
                end
                WAIT: begin
                    if (dmem_ack) begin
                        state    <= DONE;
                        dmem_req <= 1'b0;
                    end else if (wait_cnt == WC_LAST) begin
                        state    <= ERR;
                        dmem_req <= 1'b0;
                        dmem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                // DONE always returns to IDLE so the finished access cannot re-trigger.
                DONE:    state <= IDLE;
                ERR:     state <= ERR;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if ((|stall) && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; a second instance with CNT_W=4 covers counter saturation.
module tb_pipe_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_regdst;
    logic        ex_MemRead, ex_branch_taken, mem_MemRead, mem_MemWrite, dmem_ack;
    logic [4:0]  stall, s_stall;
    logic        flush_if_id, flush_id_ex, wb_bubble, dmem_req, dmem_err;
    logic        s_fif, s_fie, s_wbb, s_req, s_err;
    logic [15:0] stall_cnt;
    logic [3:0]  s_cnt;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.TIMEOUT(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_MemRead(ex_MemRead),
        .ex_regdst(ex_regdst), .ex_branch_taken(ex_branch_taken), .mem_MemRead(mem_MemRead),
        .mem_MemWrite(mem_MemWrite), .dmem_ack(dmem_ack), .stall(stall),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .wb_bubble(wb_bubble),
        .dmem_req(dmem_req), .dmem_err(dmem_err), .stall_cnt(stall_cnt));

    pipe_ctrl #(.TIMEOUT(16), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_MemRead(ex_MemRead),
        .ex_regdst(ex_regdst), .ex_branch_taken(ex_branch_taken), .mem_MemRead(mem_MemRead),
        .mem_MemWrite(mem_MemWrite), .dmem_ack(dmem_ack), .stall(s_stall),
        .flush_if_id(s_fif), .flush_id_ex(s_fie), .wb_bubble(s_wbb),
        .dmem_req(s_req), .dmem_err(s_err), .stall_cnt(s_cnt));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; id_rs = 5'd0; id_rt = 5'd0; ex_regdst = 5'd0;
        ex_MemRead = 1'b0; ex_branch_taken = 1'b1; mem_MemRead = 1'b1;
        mem_MemWrite = 1'b0; dmem_ack = 1'b0;
        repeat (2) next;
        #1;
        chk("rst_stall", stall, 5'b00000);
        chk("rst_bubble", wb_bubble, 0);
        chk("rst_flush", {flush_if_id, flush_id_ex}, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_err", dmem_err, 0);
        chk("rst_cnt", stall_cnt, 0);
        ex_branch_taken = 1'b0; mem_MemRead = 1'b0;
        rst = 1'b1;

        // Load, ack on third WAIT cycle
        next; mem_MemRead = 1'b1; #1;
        chk("ld_idle_stall", stall, 5'b01111);
        chk("ld_idle_bubble", wb_bubble, 1);
        chk("ld_idle_req", dmem_req, 0);
        for (int i = 0; i < 3; i++) begin
            next; dmem_ack = (i == 2); #1;
            chk("ld_wait_req", dmem_req, 1);
            chk("ld_wait_stall", stall, 5'b01111);
        end
        next; dmem_ack = 1'b0; #1;
        chk("ld_done_stall", stall, 5'b00000);
        chk("ld_done_bubble", wb_bubble, 0);
        chk("ld_done_req", dmem_req, 0);
        chk("ld_cnt", stall_cnt, 4);
        next; mem_MemRead = 1'b0; #1;
        chk("ld_idle_after", stall, 5'b00000);
        chk("ld_no_retrigger", dmem_req, 0);

        // Load-use hazard on rt, then r0 destination ignored
        next; ex_MemRead = 1'b1; ex_regdst = 5'd5; id_rt = 5'd5; id_rs = 5'd2; #1;
        chk("lu_stall", stall, 5'b00011);
        chk("lu_flush_ex", flush_id_ex, 1);
        chk("lu_flush_if", flush_if_id, 0);
        next; ex_MemRead = 1'b0; #1;
        chk("lu_one_cycle", stall, 5'b00000);
        chk("lu_cnt", stall_cnt, 5);
        next; ex_MemRead = 1'b1; ex_regdst = 5'd0; id_rt = 5'd0; id_rs = 5'd0; #1;
        chk("lu_r0_stall", stall, 5'b00000);
        chk("lu_r0_flush", flush_id_ex, 0);
        next; ex_regdst = 5'd7; id_rs = 5'd7; ex_branch_taken = 1'b1; #1;
        chk("br_over_lu_stall", stall, 5'b00000);
        chk("br_over_lu_flush", {flush_if_id, flush_id_ex}, 2'b11);

        // Branch held through a memory stall
        next; ex_MemRead = 1'b0; mem_MemRead = 1'b1; #1;
        chk("brm_idle_flush", {flush_if_id, flush_id_ex}, 2'b00);
        chk("brm_idle_stall", stall, 5'b01111);
        for (int i = 0; i < 2; i++) begin
            next; dmem_ack = (i == 1); #1;
            chk("brm_wait_flush", {flush_if_id, flush_id_ex}, 2'b00);
        end
        next; dmem_ack = 1'b0; #1;
        chk("brm_done_flush", {flush_if_id, flush_id_ex}, 2'b11);
        chk("brm_done_stall", stall, 5'b00000);
        chk("brm_cnt", stall_cnt, 8);
        next; ex_branch_taken = 1'b0; mem_MemRead = 1'b0;

        // Store with no ack: 16 WAIT cycles then ERR
        next; mem_MemWrite = 1'b1; #1;
        chk("to_idle_stall", stall, 5'b01111);
        for (int i = 0; i < 16; i++) begin
            next; #1;
            chk("to_wait_req", dmem_req, 1);
            chk("to_wait_err", dmem_err, 0);
        end
        next; mem_MemWrite = 1'b0; #1;
        chk("to_err", dmem_err, 1);
        chk("to_err_req", dmem_req, 0);
        chk("to_err_stall", stall, 5'b01111);
        chk("to_cnt", stall_cnt, 25);
        chk("sat_cnt", s_cnt, 4'hF);
        repeat (3) next;
        #1;
        chk("to_err_held", stall, 5'b01111);
        chk("to_err_sticky", dmem_err, 1);
        chk("to_cnt_held", stall_cnt, 28);
        chk("sat_no_wrap", s_cnt, 4'hF);

        // Reset out of ERR, then reset mid-WAIT
        #2 rst = 1'b0; #1;
        chk("rerr_err", dmem_err, 0);
        chk("rerr_stall", stall, 5'b00000);
        chk("rerr_cnt", stall_cnt, 0);
        next; rst = 1'b1;
        next; mem_MemRead = 1'b1;
        next; next; #1;
        chk("rw_req_before", dmem_req, 1);
        #2 rst = 1'b0; #1;
        chk("rw_req", dmem_req, 0);
        chk("rw_stall", stall, 5'b00000);
        chk("rw_cnt", stall_cnt, 0);
        next; rst = 1'b1; #1;
        chk("rw_idle_stall", stall, 5'b01111);
        chk("rw_idle_req", dmem_req, 0);
        for (int i = 0; i < 16; i++) begin
            next; #1;
            chk("rw_wait_err", dmem_err, 0);
        end
        next; #1;
        chk("rw_timeout_err", dmem_err, 1);
        mem_MemRead = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end
endmodule
